// File: rtl/mem_rr_arbiter_pkg.sv
// Shared types and defaults for the two-requester RAM arbiter.
package mem_rr_arbiter_pkg;

  localparam int DEF_AW = 4;
  localparam int DEF_DW = 8;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    OWN0 = 2'd1,
    OWN1 = 2'd2
  } arb_state_e;

  typedef logic rq_idx_t;

  function automatic arb_state_e own_state(input rq_idx_t idx);
    return idx ? OWN1 : OWN0;
  endfunction

endpackage

// File: rtl/mem_rr_arbiter_rr_pick2.sv
// Combinational 2-way round-robin chooser; an owner excludes the other requester.
module rr_pick2
  import mem_rr_arbiter_pkg::*;
(
  input  logic [1:0] req_i,
  input  rq_idx_t    last_i,
  input  logic       owner_valid_i,
  input  rq_idx_t    owner_i,
  output logic [1:0] gnt_o
);

  always_comb begin
    gnt_o = 2'b00;
    if (owner_valid_i) begin
      gnt_o[owner_i] = req_i[owner_i];
    end else if (&req_i) begin
      gnt_o[~last_i] = 1'b1;
    end else begin
      gnt_o = req_i;
    end
  end

endmodule

// File: rtl/mem_rr_arbiter.sv
// Round-robin arbiter with optional lock in front of a single-port sync-read RAM.
// Optional lock-starvation bound enabled by MEM_RR_ARBITER_STARVE_EN.
module mem_rr_arbiter
  import mem_rr_arbiter_pkg::*;
#(
  parameter int AW       = DEF_AW,
  parameter int DW       = DEF_DW,
  parameter int MAX_LOCK = 8
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          r0_req,
  input  logic          r0_lock,
  input  logic          r0_we,
  input  logic [AW-1:0] r0_adr,
  input  logic [DW-1:0] r0_dat_w,
  output logic          r0_gnt,
  output logic          r0_rvalid,
  output logic [DW-1:0] r0_dat_r,
  input  logic          r1_req,
  input  logic          r1_lock,
  input  logic          r1_we,
  input  logic [AW-1:0] r1_adr,
  input  logic [DW-1:0] r1_dat_w,
  output logic          r1_gnt,
  output logic          r1_rvalid,
  output logic [DW-1:0] r1_dat_r,
  output logic [AW-1:0] mem_adr,
  output logic          mem_we,
  output logic [DW-1:0] mem_dat_w,
  input  logic [DW-1:0] mem_dat_r
);

  arb_state_e state_q, state_d;
  rq_idx_t    last_q, last_d;
  logic       rvalid_q, rvalid_d;
  rq_idx_t    rown_q, rown_d;

  logic [1:0] req, lock, gnt_raw, gnt;
  logic       owner_valid, xfer, sel_we;
  rq_idx_t    owner, win, sel;

  assign req         = {r1_req, r0_req};
  assign lock        = {r1_lock, r0_lock};
  assign owner_valid = (state_q != IDLE);
  assign owner       = (state_q == OWN1);

  rr_pick2 u_pick (
    .req_i         (req),
    .last_i        (last_q),
    .owner_valid_i (owner_valid),
    .owner_i       (owner),
    .gnt_o         (gnt_raw)
  );

  // Nothing is accepted while reset is asserted.
  assign gnt    = rst ? 2'b00 : gnt_raw;
  assign r0_gnt = gnt[0];
  assign r1_gnt = gnt[1];
  assign xfer   = |gnt;
  assign win    = gnt[1];

  // Idle cycles park the port on the last winner's inputs.
  assign sel       = xfer ? win : last_q;
  assign mem_adr   = sel ? r1_adr : r0_adr;
  assign mem_dat_w = sel ? r1_dat_w : r0_dat_w;
  assign sel_we    = sel ? r1_we : r0_we;
  assign mem_we    = xfer & sel_we;

  assign rvalid_d = xfer & ~sel_we;
  assign rown_d   = xfer ? win : rown_q;

  assign r0_rvalid = rvalid_q & ~rown_q & ~rst;
  assign r1_rvalid = rvalid_q &  rown_q & ~rst;
  assign r0_dat_r  = mem_dat_r;
  assign r1_dat_r  = mem_dat_r;

`ifdef MEM_RR_ARBITER_STARVE_EN
  localparam int CW = $clog2(MAX_LOCK + 1);
  logic [CW-1:0] cnt_q, cnt_d;
`endif

  always_comb begin
    state_d = state_q;
    last_d  = xfer ? win : last_q;
    unique case (state_q)
      IDLE:       if (xfer && lock[win]) state_d = own_state(win);
      OWN0, OWN1: if (!lock[owner])      state_d = IDLE;
      default:    state_d = IDLE;
    endcase
`ifdef MEM_RR_ARBITER_STARVE_EN
    cnt_d = '0;
    // Count only while the owner keeps its lock and the other side is waiting.
    if (owner_valid && lock[owner] && req[~owner]) begin
      cnt_d = cnt_q + 1'b1;
      if (cnt_d == CW'(MAX_LOCK)) begin
        state_d = IDLE;
        last_d  = owner;
        cnt_d   = '0;
      end
    end
`endif
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      last_q   <= 1'b1;
      rvalid_q <= 1'b0;
      rown_q   <= 1'b0;
`ifdef MEM_RR_ARBITER_STARVE_EN
      cnt_q    <= '0;
`endif
    end else begin
      state_q  <= state_d;
      last_q   <= last_d;
      rvalid_q <= rvalid_d;
      rown_q   <= rown_d;
`ifdef MEM_RR_ARBITER_STARVE_EN
      cnt_q    <= cnt_d;
`endif
    end
  end

endmodule

// File: tb/tb_mem_rr_arbiter.sv
// Randomized + directed bench for mem_rr_arbiter against a cycle-level rule model.
module tb_mem_rr_arbiter;
  localparam int AW = 4;
  localparam int DW = 8;
  localparam int ML = 4;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic [1:0]    req, lock, we;
  logic [AW-1:0] adr [2];
  logic [DW-1:0] dw  [2];
  logic          g0, g1, v0, v1;
  logic [DW-1:0] d0, d1;
  logic [AW-1:0] mem_adr;
  logic          mem_we;
  logic [DW-1:0] mem_dat_w, mem_dat_r;

  always #5 clk = ~clk;

  mem_rr_arbiter #(.AW(AW), .DW(DW), .MAX_LOCK(ML)) dut (
    .clk(clk), .rst(rst),
    .r0_req(req[0]), .r0_lock(lock[0]), .r0_we(we[0]), .r0_adr(adr[0]), .r0_dat_w(dw[0]),
    .r0_gnt(g0), .r0_rvalid(v0), .r0_dat_r(d0),
    .r1_req(req[1]), .r1_lock(lock[1]), .r1_we(we[1]), .r1_adr(adr[1]), .r1_dat_w(dw[1]),
    .r1_gnt(g1), .r1_rvalid(v1), .r1_dat_r(d1),
    .mem_adr(mem_adr), .mem_we(mem_we), .mem_dat_w(mem_dat_w), .mem_dat_r(mem_dat_r)
  );

  // Environment RAM: synchronous read, one-cycle latency
  logic [DW-1:0] ram [16];
  always @(posedge clk) begin
    if (mem_we) ram[mem_adr] <= mem_dat_w;
    mem_dat_r <= ram[mem_adr];
  end

  // Reference model state
  logic [DW-1:0] shadow [16];
  int owner, last, cnt, pwho;
  bit pend;
  logic [DW-1:0] pdat;
  bit [1:0] last_eg;
  int n_chk = 0, n_pass = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
  endtask

  task automatic set(input int i, input bit r, input bit l, input bit w, input int a, input int d);
    req[i] = r; lock[i] = l; we[i] = w; adr[i] = AW'(a); dw[i] = DW'(d);
  endtask

  task automatic idle();
    set(0, 0, 0, 0, 0, 0);
    set(1, 0, 0, 0, 0, 0);
  endtask

  // Check one cycle against the model, advance the model, move to next negedge.
  task automatic cyc();
    bit [1:0] eg;
    int w;
    #1;
    eg = 2'b00;
    if (rst) begin
      chk("rst_gnt0", g0, 0); chk("rst_gnt1", g1, 0);
      chk("rst_rv0", v0, 0);  chk("rst_rv1", v1, 0);
      chk("rst_we", mem_we, 0);
      owner = -1; last = 1; cnt = 0; pend = 0;
    end else begin
      if (owner >= 0) eg[owner] = req[owner];
      else if (req == 2'b11) eg[1-last] = 1'b1;
      else eg = req;
      chk("gnt0", g0, eg[0]);
      chk("gnt1", g1, eg[1]);
      chk("rv0", v0, pend && pwho == 0);
      chk("rv1", v1, pend && pwho == 1);
      if (pend) chk("dat_r", pwho ? d1 : d0, pdat);
      w = eg[1] ? 1 : 0;
      if (eg != 0) begin
        chk("mem_we", mem_we, we[w]);
        chk("mem_adr", mem_adr, adr[w]);
        if (we[w]) chk("mem_dat_w", mem_dat_w, dw[w]);
      end else begin
        chk("mem_we_idle", mem_we, 0);
        chk("mem_adr_idle", mem_adr, adr[last]);
      end
      pend = 0;
      if (eg != 0) begin
        if (we[w]) shadow[adr[w]] = dw[w];
        else begin pend = 1; pwho = w; pdat = shadow[adr[w]]; end
        last = w;
      end
      if (owner < 0) begin
        if (eg != 0 && lock[w]) begin owner = w; cnt = 0; end
      end else if (!lock[owner]) begin
        owner = -1; cnt = 0;
      end
`ifdef MEM_RR_ARBITER_STARVE_EN
      else if (req[1-owner]) begin
        cnt++;
        if (cnt == ML) begin last = owner; owner = -1; cnt = 0; end
      end else cnt = 0;
`endif
    end
    last_eg = eg;
    @(negedge clk);
  endtask

  task automatic do_reset();
    idle(); rst = 1; cyc(); rst = 0;
  endtask

  initial begin
    for (int i = 0; i < 16; i++) begin ram[i] = DW'($urandom); shadow[i] = ram[i]; end
    ram[3] = 8'hFE; shadow[3] = 8'hFE;
    owner = -1; last = 1; cnt = 0; pend = 0; pwho = 0; pdat = '0; last_eg = 0;
    idle();
    @(negedge clk);
    rst = 1; cyc(); cyc(); rst = 0;

    // 1: single read, 1-cycle latency
    set(0, 1, 0, 0, 3, 0);
    #1 chk("t1_gnt0", g0, 1);
    cyc();
    idle();
    #1 chk("t1_rv0", v0, 1); chk("t1_dat", d0, 8'hFE); chk("t1_rv1", v1, 0);
    cyc();

    // 2: continuous contention alternates; read-after-write sees new data
    do_reset();
    set(0, 1, 0, 1, 5, 8'h11);
    set(1, 1, 0, 0, 5, 0);
    for (int k = 0; k < 4; k++) begin
      #1 chk("t2_gnt0", g0, (k % 2) == 0); chk("t2_gnt1", g1, (k % 2) == 1);
      if (k == 2) begin chk("t2_rv1", v1, 1); chk("t2_rd", d1, 8'h11); end
      cyc();
    end
    idle(); cyc();

    // 3: locked read-modify-write blocks r1
    do_reset();
    set(0, 1, 1, 0, 2, 0);
    set(1, 1, 0, 0, 7, 0);
    #1 chk("t3_g0a", g0, 1); chk("t3_g1a", g1, 0);
    cyc();
    set(0, 1, 0, 1, 2, 8'h5A);
    #1 chk("t3_g0b", g0, 1); chk("t3_g1b", g1, 0);
    cyc();
    set(0, 0, 0, 0, 0, 0);
    #1 chk("t3_g1c", g1, 1);
    cyc();
    idle(); cyc();

    // 4: reset drops a pending read and restores r0 priority
    do_reset();
    set(1, 1, 0, 0, 4, 0);
    #1 chk("t4_g1", g1, 1);
    cyc();
    idle(); rst = 1; cyc(); rst = 0;
    set(0, 1, 0, 0, 1, 0);
    set(1, 1, 0, 0, 4, 0);
    #1 chk("t4_rv1", v1, 0); chk("t4_win0", g0, 1);
    cyc();
    idle(); cyc();

`ifdef MEM_RR_ARBITER_STARVE_EN
    // 5: lock starvation bound
    do_reset();
    set(0, 1, 1, 0, 1, 0);
    set(1, 1, 0, 0, 6, 0);
    for (int k = 0; k < 6; k++) begin
      #1 chk("t5_g1", g1, k == 5);
      cyc();
    end
    idle(); cyc();
`endif

    // 6: idle lock by r1 still blocks r0
    do_reset();
    set(1, 1, 1, 0, 8, 0);
    #1 chk("t6_g1", g1, 1);
    cyc();
    set(1, 0, 1, 0, 8, 0);
    set(0, 1, 0, 1, 9, 8'h33);
    for (int k = 0; k < 3; k++) begin
      #1 chk("t6_g0blk", g0, 0); chk("t6_we", mem_we, 0);
      cyc();
    end
    set(1, 0, 0, 0, 8, 0);
    #1 chk("t6_g0drop", g0, 0);
    cyc();
    #1 chk("t6_g0go", g0, 1);
    cyc();
    idle(); cyc();

    // Random traffic: requests held stable until granted
    for (int n = 0; n < 600; n++) begin
      for (int i = 0; i < 2; i++) begin
        if (!req[i] || last_eg[i]) begin
          req[i] = ($urandom % 3) != 0;
          we[i]  = $urandom % 2;
          adr[i] = AW'($urandom);
          dw[i]  = DW'($urandom);
        end
        lock[i] = ($urandom % 4) == 0;
      end
      rst = ($urandom % 97) == 0;
      cyc();
      rst = 0;
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
